// File: rtl/interval_timer_if.sv
// CPU register-port bundle for interval_timer: access strobe, address, data both ways and the irq line.
interface interval_timer_if;
  logic       ce;
  logic       wren;
  logic [1:0] addr;
  logic [7:0] from_cpu;
  logic [7:0] to_cpu;
  logic       irq;

  modport master (
    output ce, wren, addr, from_cpu,
    input  to_cpu, irq
  );

  modport slave (
    input  ce, wren, addr, from_cpu,
    output to_cpu, irq
  );
endinterface

// File: rtl/interval_timer.sv
// 16-bit down-counting interval timer with prescaler, auto-reload/one-shot modes,
// sticky expire/overrun status and a tear-free latched count readback.
module interval_timer #(
  parameter logic [15:0] RELOAD_INIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  interval_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_CNT_LO = 2'd0,
    REG_CNT_HI = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STAT   = 2'd3
  } reg_sel_e;

  logic [15:0] reload;
  logic [15:0] count;
  logic [5:0]  ctrl;
  logic [6:0]  prescaler;
  logic [1:0]  status;
  logic [7:0]  hi_latch;

  reg_sel_e    sel;
  logic        en;
  logic        auto_rl;
  logic [2:0]  psel;
  logic        wr;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        load;
  logic [6:0]  mask;
  logic        tick;
  logic        tick_eff;
  logic        expire;
  logic [1:0]  status_masked;
  logic [1:0]  status_nxt;
  logic [7:0]  rd_data;

  always_comb begin
    sel      = reg_sel_e'(bus.addr);
    en       = ctrl[0];
    auto_rl  = ctrl[1];
    psel     = ctrl[4:2];
    wr       = bus.ce & bus.wren;
    ctrl_wr  = wr && (sel == REG_CTRL);
    stat_wr  = wr && (sel == REG_STAT);
    load     = ctrl_wr & bus.from_cpu[7];
    mask     = 7'((8'd1 << psel) - 8'd1);
    tick     = en && ((prescaler & mask) == mask);
    // A LOAD, or a CTRL write that disables the timer, suppresses the tick entirely.
    tick_eff = tick & ~load & ~(ctrl_wr & ~bus.from_cpu[0]);
    expire   = tick_eff && (count == '0);

    status_masked = stat_wr ? (status & bus.from_cpu[1:0]) : status;
    status_nxt    = status_masked;
    // Overrun is judged against EXP after any same-cycle clear, so a clear always wins for OVR.
    if (expire) begin
      status_nxt[0] = 1'b1;
      status_nxt[1] = status_masked[1] | status_masked[0];
    end

    rd_data = '0;
    case (sel)
      REG_CNT_LO: rd_data = count[7:0];
      REG_CNT_HI: rd_data = hi_latch;
      REG_CTRL:   rd_data = {2'b00, ctrl};
      REG_STAT:   rd_data = {6'b0, status};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reload     <= RELOAD_INIT;
      count      <= RELOAD_INIT;
      ctrl       <= '0;
      prescaler  <= '0;
      status     <= '0;
      hi_latch   <= '0;
      bus.to_cpu <= '0;
      bus.irq    <= 1'b0;
    end else begin
      if (bus.ce) begin
        bus.to_cpu <= rd_data;
        if (sel == REG_CNT_LO)
          hi_latch <= count[15:8];
      end

      if (wr && (sel == REG_CNT_LO))
        reload[7:0] <= bus.from_cpu;
      if (wr && (sel == REG_CNT_HI))
        reload[15:8] <= bus.from_cpu;

      if (ctrl_wr)
        ctrl <= bus.from_cpu[5:0];
      else if (expire && !auto_rl)
        ctrl[0] <= 1'b0;

      if (load)
        prescaler <= '0;
      else if (en)
        prescaler <= prescaler + 7'd1;
      else
        prescaler <= '0;

      if (load)
        count <= reload;
      else if (tick_eff) begin
        if (count != '0)
          count <= count - 16'd1;
        else if (auto_rl)
          count <= reload;
      end

      status  <= status_nxt;
      bus.irq <= status[0];
    end
  end

endmodule
